// File: rtl/uart_cmd_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Package  : uart_cmd_pkg
// Function : Command codes and state encodings for the UART command receiver.
// Options  : UART_CMD_PARITY_EN adds the RX_PARITY state (8E1 framing).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package uart_cmd_pkg;

   localparam logic [7:0] CMD_WR_CTRL  = 8'hA0;
   localparam logic [7:0] CMD_WR_DATA  = 8'hA1;

   localparam logic [2:0] RX_IDLE      = 3'd0;
   localparam logic [2:0] RX_START     = 3'd1;
   localparam logic [2:0] RX_DATA      = 3'd2;
`ifdef UART_CMD_PARITY_EN
   localparam logic [2:0] RX_PARITY    = 3'd3;
`endif
   localparam logic [2:0] RX_STOP      = 3'd4;
   localparam logic [2:0] RX_WAIT_HIGH = 3'd5;

   localparam logic [0:0] P_CMD        = 1'b0;
   localparam logic [0:0] P_PAY        = 1'b1;

   typedef enum logic {
      TGT_CTRL = 1'b0,
      TGT_DATA = 1'b1
   } target_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_rx_core
// Function : UART receiver: line synchroniser, bit FSM, one-cycle byte strobe.
// Options  : UART_CMD_PARITY_EN selects 8E1 framing (even parity), else 8N1.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_rx_core
   import uart_cmd_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] c_bit_last  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] c_half_last = CW'(CLKS_PER_BIT / 2 - 1);
`ifdef UART_CMD_PARITY_EN
   localparam logic [2:0] c_after_data = RX_PARITY;
`else
   localparam logic [2:0] c_after_data = RX_STOP;
`endif

   logic          r_rx_meta;
   logic          r_rx_s;
   logic [2:0]    r_state;
   logic [CW-1:0] r_clk_cnt;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic          r_byte_valid;
   logic          r_frame_err;

   // Preset high so reset release never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= RX_IDLE;
         r_clk_cnt    <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else if (!ena) begin
         r_state      <= RX_IDLE;
         r_clk_cnt    <= '0;
         r_bit_cnt    <= '0;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         case (r_state)
            RX_IDLE: begin
               r_clk_cnt <= '0;
               r_bit_cnt <= '0;
               if (!r_rx_s) r_state <= RX_START;
            end
            RX_START: begin
               if (r_clk_cnt == c_half_last) begin
                  r_clk_cnt <= '0;
                  r_state   <= r_rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (r_clk_cnt == c_bit_last) begin
                  r_clk_cnt <= '0;
                  r_shift   <= {r_rx_s, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) r_state <= c_after_data;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
`ifdef UART_CMD_PARITY_EN
            RX_PARITY: begin
               if (r_clk_cnt == c_bit_last) begin
                  r_clk_cnt <= '0;
                  if (r_rx_s == ^r_shift) begin
                     r_state <= RX_STOP;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= r_rx_s ? RX_IDLE : RX_WAIT_HIGH;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
`endif
            RX_STOP: begin
               if (r_clk_cnt == c_bit_last) begin
                  r_clk_cnt <= '0;
                  if (r_rx_s) begin
                     r_byte_valid <= 1'b1;
                     r_state      <= RX_IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= RX_WAIT_HIGH;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            // A held-low line (break) must end before a new start bit counts.
            RX_WAIT_HIGH: begin
               if (r_rx_s) r_state <= RX_IDLE;
            end
            default: r_state <= RX_IDLE;
         endcase
      end
   end

   assign rx_byte    = r_shift;
   assign byte_valid = r_byte_valid;
   assign frame_err  = r_frame_err;
   assign busy       = (r_state != RX_IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_rx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_cmd_rx
// Function : UART receiver plus two-byte command parser driving ctrl/data regs.
// Options  : UART_CMD_PARITY_EN (in uart_rx_core) selects 8E1 framing.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_cmd_rx
   import uart_cmd_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       rx_i,
   output logic [7:0] ctrl_o,
   output logic [7:0] data_o,
   output logic       upd_ctrl_o,
   output logic       upd_data_o,
   output logic       frame_err_o,
   output logic       cmd_err_o,
   output logic       busy_o
);

   localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW        = $clog2(TMO_LIMIT + 1);
   localparam logic [TW-1:0] c_tmo_last = TW'(TMO_LIMIT - 1);

   logic [7:0]    w_rx_byte;
   logic          w_byte_valid;
   logic          w_frame_err;
   logic          w_rx_busy;

   logic [0:0]    r_pstate;
   target_e       r_target;
   logic [TW-1:0] r_tmo_cnt;
   logic          r_cmd_err;
   logic          r_wr_ctrl;
   logic          r_wr_data;
   logic [7:0]    r_wr_byte;
   logic [7:0]    r_ctrl;
   logic [7:0]    r_data;
   logic          r_upd_ctrl;
   logic          r_upd_data;

   uart_rx_core #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .rx         (rx_i),
      .rx_byte    (w_rx_byte),
      .byte_valid (w_byte_valid),
      .frame_err  (w_frame_err),
      .busy       (w_rx_busy)
   );

   // byte_valid is checked before the timeout so a payload arriving on the
   // expiry cycle still wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pstate  <= P_CMD;
         r_target  <= TGT_CTRL;
         r_tmo_cnt <= '0;
         r_cmd_err <= 1'b0;
         r_wr_ctrl <= 1'b0;
         r_wr_data <= 1'b0;
         r_wr_byte <= '0;
      end else if (!ena) begin
         r_pstate  <= P_CMD;
         r_tmo_cnt <= '0;
         r_cmd_err <= 1'b0;
         r_wr_ctrl <= 1'b0;
         r_wr_data <= 1'b0;
      end else begin
         r_cmd_err <= 1'b0;
         r_wr_ctrl <= 1'b0;
         r_wr_data <= 1'b0;
         case (r_pstate)
            P_CMD: begin
               r_tmo_cnt <= '0;
               if (w_byte_valid) begin
                  if (w_rx_byte == CMD_WR_CTRL) begin
                     r_pstate <= P_PAY;
                     r_target <= TGT_CTRL;
                  end else if (w_rx_byte == CMD_WR_DATA) begin
                     r_pstate <= P_PAY;
                     r_target <= TGT_DATA;
                  end else begin
                     r_cmd_err <= 1'b1;
                  end
               end
            end
            P_PAY: begin
               if (w_byte_valid) begin
                  r_wr_ctrl <= (r_target == TGT_CTRL);
                  r_wr_data <= (r_target == TGT_DATA);
                  r_wr_byte <= w_rx_byte;
                  r_pstate  <= P_CMD;
               end else if (r_tmo_cnt == c_tmo_last) begin
                  r_cmd_err <= 1'b1;
                  r_pstate  <= P_CMD;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
            end
            default: r_pstate <= P_CMD;
         endcase
      end
   end

   // Output stage: the register and its update pulse change on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl     <= '0;
         r_data     <= '0;
         r_upd_ctrl <= 1'b0;
         r_upd_data <= 1'b0;
      end else begin
         r_upd_ctrl <= 1'b0;
         r_upd_data <= 1'b0;
         if (ena && r_wr_ctrl) begin
            r_ctrl     <= r_wr_byte;
            r_upd_ctrl <= 1'b1;
         end
         if (ena && r_wr_data) begin
            r_data     <= r_wr_byte;
            r_upd_data <= 1'b1;
         end
      end
   end

   assign ctrl_o      = r_ctrl;
   assign data_o      = r_data;
   assign upd_ctrl_o  = r_upd_ctrl;
   assign upd_data_o  = r_upd_data;
   assign frame_err_o = w_frame_err;
   assign cmd_err_o   = r_cmd_err;
   assign busy_o      = w_rx_busy || (r_pstate == P_PAY);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_uart_cmd_rx
// Function : Scoreboard bench for uart_cmd_rx (CLKS_PER_BIT = 8).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_uart_cmd_rx;

   localparam int CPB = 8;
`ifdef UART_CMD_PARITY_EN
   localparam int FRAME_BITS = 10;
`else
   localparam int FRAME_BITS = 9;
`endif
   // Start bit driven just before posedge 1: 2 sync flops + idle detect put
   // START at edge 3, mid-start at 3+CPB/2, then one sample per bit after that.
   localparam int SMP = 3 + CPB / 2 + FRAME_BITS * CPB;
   localparam int TMO = 32 * CPB;

   typedef struct {
      logic [7:0] val;
      int         cyc;
   } evt_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       rx_i = 1'b1;
   logic [7:0] ctrl_o;
   logic [7:0] data_o;
   logic       upd_ctrl_o;
   logic       upd_data_o;
   logic       frame_err_o;
   logic       cmd_err_o;
   logic       busy_o;

   evt_t q_ctrl[$];
   evt_t q_data[$];
   evt_t q_cerr[$];
   evt_t q_ferr[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   uart_cmd_rx #(
      .CLKS_PER_BIT (CPB),
      .TIMEOUT_BITS (32)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .rx_i        (rx_i),
      .ctrl_o      (ctrl_o),
      .data_o      (data_o),
      .upd_ctrl_o  (upd_ctrl_o),
      .upd_data_o  (upd_data_o),
      .frame_err_o (frame_err_o),
      .cmd_err_o   (cmd_err_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [31:0] outs();
      return {11'b0, ctrl_o, data_o, upd_ctrl_o, upd_data_o, frame_err_o, cmd_err_o, busy_o};
   endfunction

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic match(string name, bit have, evt_t e, logic [7:0] got);
      n_tests++;
      if (!have) begin
         n_fail++;
         $display("FAIL %s: unexpected pulse at cycle %0d, value %h", name, cyc, got);
      end else if (got !== e.val || cyc != e.cyc) begin
         n_fail++;
         $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d", name, got, cyc, e.val, e.cyc);
      end
   endtask

   // Monitor: every output pulse must match the next queued expectation.
   always @(negedge clk) begin
      evt_t e;
      bit   have;
      if (rst_n) begin
         if (upd_ctrl_o) begin
            have = (q_ctrl.size() > 0);
            if (have) e = q_ctrl.pop_front();
            match("upd_ctrl", have, e, ctrl_o);
         end
         if (upd_data_o) begin
            have = (q_data.size() > 0);
            if (have) e = q_data.pop_front();
            match("upd_data", have, e, data_o);
         end
         if (cmd_err_o) begin
            have = (q_cerr.size() > 0);
            if (have) e = q_cerr.pop_front();
            match("cmd_err", have, e, 8'h00);
         end
         if (frame_err_o) begin
            have = (q_ferr.size() > 0);
            if (have) e = q_ferr.pop_front();
            match("frame_err", have, e, 8'h00);
         end
      end
   end

   task automatic bit_time(logic v);
      rx_i = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send(logic [7:0] b, logic stop_lvl, int nbits, output int t0);
      t0 = cyc;
      bit_time(1'b0);
      for (int i = 0; i < nbits; i++) bit_time(b[i]);
      if (nbits == 8) begin
`ifdef UART_CMD_PARITY_EN
         bit_time(^b);
`endif
         bit_time(stop_lvl);
      end
   endtask

   task automatic send_byte(logic [7:0] b);
      int t;
      send(b, 1'b1, 8, t);
   endtask

   task automatic write_reg(logic [7:0] cmd, logic [7:0] pay);
      int t;
      send_byte(cmd);
      t = cyc;
      if (cmd == 8'hA0) q_ctrl.push_back('{pay, t + SMP + 2});
      else              q_data.push_back('{pay, t + SMP + 2});
      send(pay, 1'b1, 8, t);
   endtask

   task automatic drained(string name);
      repeat (4) @(negedge clk);
      check(name, 32'(q_ctrl.size() + q_data.size() + q_cerr.size() + q_ferr.size()), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst_n = 1'b0;
      ena   = 1'b1;
      rx_i  = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", outs(), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("first_edge_outputs", outs(), 32'd0);
      repeat (4) @(negedge clk);

      // Single control write
      write_reg(8'hA0, 8'h04);
      drained("t1_drain");
      check("t1_data_hold", 32'(data_o), 32'h00);

      // Data then control write
      write_reg(8'hA1, 8'h97);
      write_reg(8'hA0, 8'h24);
      drained("t2_drain");
      check("t2_regs", 32'({ctrl_o, data_o}), 32'h2497);

      // Invalid command byte
      t = cyc;
      q_cerr.push_back('{8'h00, t + SMP + 1});
      send(8'h5A, 1'b1, 8, t);
      check("t3_busy_after_bad_cmd", 32'(busy_o), 32'd0);
      write_reg(8'hA0, 8'h03);
      drained("t3_drain");
      check("t3_ctrl", 32'(ctrl_o), 32'h03);

      // Payload timeout, then an orphan payload byte
      t = cyc;
      q_cerr.push_back('{8'h00, t + SMP + 1 + TMO});
      send(8'hA1, 1'b1, 8, t);
      check("t4_busy_pending", 32'(busy_o), 32'd1);
      repeat (33 * CPB) @(negedge clk);
      check("t4_busy_after_timeout", 32'(busy_o), 32'd0);
      drained("t4_drain_timeout");
      t = cyc;
      q_cerr.push_back('{8'h00, t + SMP + 1});
      send(8'h11, 1'b1, 8, t);
      drained("t4_drain_orphan");
      check("t4_data_unchanged", 32'(data_o), 32'h97);

      // Stop bit low with the line held low
      t = cyc;
      q_ferr.push_back('{8'h00, t + SMP});
      send(8'hA0, 1'b0, 8, t);
      repeat (2 * CPB) @(negedge clk);
      check("t5_busy_line_low", 32'(busy_o), 32'd1);
      rx_i = 1'b1;
      repeat (5) @(negedge clk);
      check("t5_busy_line_high", 32'(busy_o), 32'd0);
      drained("t5_drain");
      check("t5_ctrl_unchanged", 32'(ctrl_o), 32'h03);

      // Reset mid-payload
      send_byte(8'hA0);
      send(8'h55, 1'b1, 5, t);
      check("t6_busy_mid_payload", 32'(busy_o), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_in_reset", outs(), 32'd0);
      rx_i = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t6_after_release", outs(), 32'd0);
      repeat (4) @(negedge clk);
      write_reg(8'hA0, 8'h07);
      drained("t6_drain");
      check("t6_ctrl", 32'(ctrl_o), 32'h07);

      // Enable dropped mid-payload
      send_byte(8'hA1);
      send(8'h3C, 1'b1, 5, t);
      ena = 1'b0;
      @(negedge clk);
      check("t7_ena_low_hold", outs(), {11'b0, 8'h07, 8'h00, 5'b0});
      rx_i = 1'b1;
      repeat (4) @(negedge clk);
      ena = 1'b1;
      repeat (4) @(negedge clk);
      write_reg(8'hA1, 8'h6B);
      drained("t7_drain");
      check("t7_regs", 32'({ctrl_o, data_o}), 32'h076B);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
